lms_adapt_ctrl: RTL and testbench
=================================

# lms_adapt_ctrl

Adaptation sequencer for the LMS FIR core. It accepts (x, d) sample pairs over a valid/ready handshake and strobes the core once per sample. It decides whether each sample also updates the weights (training) or only filters (frozen), and returns (y, e) on an output handshake. Training ends on measured convergence, on a timeout, or on an explicit freeze request.

## Interface
- WIDTH, 16: sample, y and e width (signed).
- CORE_LAT, 1: cycles from core_shift to valid core_y/core_e (≥1).
- WIN_LOG2, 6: log2 of the convergence window length in samples.
- CONV_WINDOWS, 4: consecutive sub-threshold windows required to declare convergence.
- MAX_TRAIN, 4096: training sample limit before forced freeze.
- ACC_W, WIDTH+WIN_LOG2: width of the window |e| accumulator and of thresh.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request: clear weights and begin training
- freeze_req  in  1  one-cycle request: stop adaptation
- thresh  in  ACC_W  unsigned window |e| sum threshold
- s_valid / s_ready  in / out  1  input handshake
- s_x, s_d  in  WIDTH  input sample and desired value
- core_x, core_d  out  WIDTH  registered sample to core, held between accepts
- core_shift  out  1  one-cycle strobe: core consumes core_x/core_d
- core_adapt  out  1  qualifies core_shift: update weights this sample
- core_clear  out  1  one-cycle weight clear
- core_y, core_e  in  WIDTH  core output and error, valid CORE_LAT after core_shift
- m_valid / m_ready  out / in  1  output handshake
- m_y, m_e  out  WIDTH  captured core_y/core_e
- state  out  2  IDLE=0, CLEAR=1, TRAIN=2, RUN=3
- converged, timeout  out  1  sticky completion flags

## Operation
- Reset: state=IDLE, all outputs 0, all counters/accumulator 0, no sample in flight.
- IDLE: s_ready=0. start → CLEAR.
- CLEAR: core_clear=1 for exactly one cycle. Zero acc, win_cnt, good_cnt, train_cnt, converged, timeout. → TRAIN next cycle.
- TRAIN/RUN sample flow (one sample in flight max): s_ready=1 only when nothing is in flight, m_valid=0, and no start is pending.
  - On accept, register s_x/s_d into core_x/core_d.
  - Next cycle, core_shift=1 and core_adapt=(state==TRAIN).
  - CORE_LAT cycles after that, capture core_y/core_e into m_y/m_e.
  - m_valid holds until m_valid&&m_ready.
- Convergence (TRAIN only, at each capture):
  - acc += |core_e|, with |−2^(WIDTH−1)| taken as 2^(WIDTH−1)−1.
  - win_cnt and train_cnt increment.
  - On win_cnt wrap (2^WIN_LOG2 captures): acc<thresh → good_cnt++, else good_cnt=0. acc is cleared.
  - good_cnt==CONV_WINDOWS → RUN, converged=1.
  - Else train_cnt==MAX_TRAIN → RUN, timeout=1.
  - If both hit on the same capture, converged wins and timeout stays 0.
- freeze_req in TRAIN:
  - If no sample is in flight, go to RUN next cycle.
  - Otherwise latch the request and go to RUN on the capture cycle, after that capture's accumulation.
  - converged and timeout remain 0.
  - freeze_req is ignored in IDLE, CLEAR and RUN.
- start in TRAIN or RUN:
  - Latch a pending start; s_ready drops.
  - Go to CLEAR once nothing is in flight and the output handshake has completed.
  - start in CLEAR is ignored.
- The core is never strobed in IDLE or CLEAR. core_shift and core_clear are never high together.

## Timing
- Accept at cycle T. core_shift at T+1. Capture at T+1+CORE_LAT. m_valid=1 from T+2+CORE_LAT.
- s_ready reasserts the cycle after the output handshake, giving a peak throughput of 1 sample per CORE_LAT+3 cycles with m_ready held high.
- State changes triggered by a capture take effect at T+2+CORE_LAT. The next accepted sample uses the new core_adapt.
- start→CLEAR→TRAIN: core_clear one cycle after start. s_ready can be 1 two cycles after start.
- Mid-operation reset drops m_valid, core_shift and core_clear immediately and discards any in-flight sample.

## Test plan
- Reset then start with CORE_LAT=1: core_clear at cycle 1, state=2 at cycle 2. Feed one sample → core_shift 1 cycle after accept with core_adapt=1, m_valid 3 cycles after accept, m_y/m_e equal the core values.
- Core model returns e=0, thresh=1: converged=1 and state=3 after exactly 4×64=256 samples. Subsequent samples have core_adapt=0.
- Core model returns e=1000, MAX_TRAIN=4096: timeout=1, converged=0, state=3 after sample 4096. Then e=−32768 saturates without acc wrap (check with a reduced window).
- freeze_req while a sample is in flight: that sample completes with core_adapt=1, the next sample has core_adapt=0, and both flags are 0.
- m_ready held 0 for 10 cycles: s_ready stays 0 and m_y stays stable. Release → s_ready=1 the next cycle.
- start asserted in RUN with a sample in flight: the sample completes, then CLEAR (core_clear=1), flags cleared, state=2. Asserting rst low mid-flight forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/lms_adapt_ctrl.sv
// Adaptation sequencer for the LMS FIR core: one sample in flight, training
// until window-based convergence, a sample-count timeout, or a freeze request.
module lms_adapt_ctrl #(
  parameter int WIDTH        = 16,
  parameter int CORE_LAT     = 1,
  parameter int WIN_LOG2     = 6,
  parameter int CONV_WINDOWS = 4,
  parameter int MAX_TRAIN    = 4096,
  parameter int ACC_W        = WIDTH + WIN_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    freeze_req,
  input  logic [ACC_W-1:0]        thresh,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic signed [WIDTH-1:0] s_d,
  output logic signed [WIDTH-1:0] core_x,
  output logic signed [WIDTH-1:0] core_d,
  output logic                    core_shift,
  output logic                    core_adapt,
  output logic                    core_clear,
  input  logic signed [WIDTH-1:0] core_y,
  input  logic signed [WIDTH-1:0] core_e,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_y,
  output logic signed [WIDTH-1:0] m_e,
  output logic [1:0]              state,
  output logic                    converged,
  output logic                    timeout
);

  localparam int TC_W = $clog2(MAX_TRAIN + 1);
  localparam int GC_W = $clog2(CONV_WINDOWS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    TRAIN = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t cur, nxt;

  logic                in_flight;
  logic [CORE_LAT-1:0] lat_pipe;
  logic                start_pend;
  logic                freeze_pend;
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [GC_W-1:0]     good_cnt;
  logic [TC_W-1:0]     train_cnt;

  logic                    active, accept, capture, train_cap, go_clear;
  logic signed [WIDTH-1:0] neg_e;
  logic [WIDTH-2:0]        mag_e;
  logic [ACC_W-1:0]        acc_sum;
  logic                    win_wrap;
  logic [GC_W-1:0]         good_upd;
  logic [TC_W-1:0]         train_upd;
  logic                    hit_conv, hit_tout;

  assign active     = (cur == TRAIN) || (cur == RUN);
  assign s_ready    = active && !in_flight && !m_valid && !start_pend;
  assign accept     = s_valid && s_ready;
  assign capture    = lat_pipe[CORE_LAT-1];
  assign train_cap  = capture && (cur == TRAIN);
  assign go_clear   = active && (start || start_pend) && !in_flight && !m_valid && !accept;
  assign core_clear = (cur == CLEAR);
  assign core_adapt = core_shift && (cur == TRAIN);
  assign state      = cur;

  // |e| saturates: negating the most-negative code stays negative.
  always_comb begin
    neg_e = -core_e;
    if (!core_e[WIDTH-1])     mag_e = core_e[WIDTH-2:0];
    else if (neg_e[WIDTH-1])  mag_e = '1;
    else                      mag_e = neg_e[WIDTH-2:0];
  end

  assign acc_sum   = acc + ACC_W'(mag_e);
  assign win_wrap  = &win_cnt;
  assign good_upd  = !win_wrap          ? good_cnt :
                     (acc_sum < thresh) ? good_cnt + GC_W'(1) : '0;
  assign train_upd = train_cnt + TC_W'(1);
  assign hit_conv  = (good_upd == GC_W'(CONV_WINDOWS));
  assign hit_tout  = (train_upd == TC_W'(MAX_TRAIN));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (start) nxt = CLEAR;
      CLEAR: nxt = TRAIN;
      TRAIN: begin
        if (go_clear)
          nxt = CLEAR;
        else if (train_cap && (hit_conv || hit_tout || freeze_pend || freeze_req))
          nxt = RUN;
        else if (freeze_req && !in_flight)
          nxt = RUN;
      end
      RUN:   if (go_clear) nxt = CLEAR;
      default: nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // Sample path: accept, strobe, wait CORE_LAT, capture, hand off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight  <= 1'b0;
      lat_pipe   <= '0;
      core_shift <= 1'b0;
      core_x     <= '0;
      core_d     <= '0;
      m_valid    <= 1'b0;
      m_y        <= '0;
      m_e        <= '0;
    end else begin
      core_shift <= accept;
      lat_pipe   <= (lat_pipe << 1) | CORE_LAT'(core_shift);
      if (accept) begin
        in_flight <= 1'b1;
        core_x    <= s_x;
        core_d    <= s_d;
      end else if (capture) begin
        in_flight <= 1'b0;
      end
      if (capture) begin
        m_valid <= 1'b1;
        m_y     <= core_y;
        m_e     <= core_e;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Pending requests and convergence bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_pend  <= 1'b0;
      freeze_pend <= 1'b0;
      acc         <= '0;
      win_cnt     <= '0;
      good_cnt    <= '0;
      train_cnt   <= '0;
      converged   <= 1'b0;
      timeout     <= 1'b0;
    end else if (cur == CLEAR) begin
      start_pend  <= 1'b0;
      freeze_pend <= 1'b0;
      acc         <= '0;
      win_cnt     <= '0;
      good_cnt    <= '0;
      train_cnt   <= '0;
      converged   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (active && start && !go_clear) start_pend <= 1'b1;
      if (nxt != TRAIN)
        freeze_pend <= 1'b0;
      else if (freeze_req && in_flight)
        freeze_pend <= 1'b1;
      if (train_cap) begin
        acc       <= win_wrap ? '0 : acc_sum;
        win_cnt   <= win_cnt + WIN_LOG2'(1);
        good_cnt  <= good_upd;
        train_cnt <= train_upd;
        if (hit_conv)      converged <= 1'b1;
        else if (hit_tout) timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Randomized bench for lms_adapt_ctrl with a behavioural window/flag model
// and a simple core stand-in (y = ~x, e = d, one cycle latency).
module tb_lms_adapt_ctrl;
  localparam int WIDTH        = 16;
  localparam int CORE_LAT     = 1;
  localparam int WIN          = 64;
  localparam int CONV_WINDOWS = 4;
  localparam int MAX_TRAIN    = 4096;
  localparam int ACC_W        = 22;

  logic              clk, rst, start, freeze_req;
  logic [ACC_W-1:0]  thresh;
  logic              s_valid, s_ready;
  logic [WIDTH-1:0]  s_x, s_d, core_x, core_d, core_y, core_e, m_y, m_e;
  logic              core_shift, core_adapt, core_clear, m_valid, m_ready;
  logic [1:0]        state;
  logic              converged, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int  mst;
  int  mags[$];
  int  good;
  bit  conv, tout, fpend;

  lms_adapt_ctrl #(
    .WIDTH(WIDTH), .CORE_LAT(CORE_LAT), .WIN_LOG2(6),
    .CONV_WINDOWS(CONV_WINDOWS), .MAX_TRAIN(MAX_TRAIN), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .freeze_req(freeze_req), .thresh(thresh),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
    .core_x(core_x), .core_d(core_d), .core_shift(core_shift),
    .core_adapt(core_adapt), .core_clear(core_clear),
    .core_y(core_y), .core_e(core_e),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_e(m_e),
    .state(state), .converged(converged), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_shift) begin
      core_y <= ~core_x;
      core_e <= core_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("shift_clear_excl", {31'd0, core_shift & core_clear}, 32'd0);
      check("shift_in_idle_clear", {31'd0, core_shift & (state < 2'd2)}, 32'd0);
    end
  end

  task automatic model_reset(input int st);
    mst = st;
    mags.delete();
    good = 0;
    conv = 0;
    tout = 0;
    fpend = 0;
  endtask

  task automatic model_capture(input int e);
    if (mst == 2) begin
      int mag;
      mag = (e == -32768) ? 32767 : ((e < 0) ? -e : e);
      mags.push_back(mag);
      if (mags.size() % WIN == 0) begin
        longint s;
        s = 0;
        for (int i = mags.size() - WIN; i < mags.size(); i++) s += mags[i];
        good = (s < longint'(thresh)) ? good + 1 : 0;
      end
      if (good == CONV_WINDOWS) begin
        mst = 3; conv = 1;
      end else if (mags.size() == MAX_TRAIN) begin
        mst = 3; tout = 1;
      end else if (fpend) begin
        mst = 3;
      end
    end
    fpend = 0;
  endtask

  task automatic wait_clear(input int exp_wait);
    int n;
    n = 0;
    while (!core_clear && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("clear_seen", {31'd0, core_clear}, 32'd1);
    if (exp_wait >= 0) check("clear_delay", n, exp_wait);
    check("clear_state", {30'd0, state}, 32'd1);
    @(negedge clk);
    check("train_state", {30'd0, state}, 32'd2);
    check("clear_one_cycle", {31'd0, core_clear}, 32'd0);
    check("flags_cleared", {30'd0, converged, timeout}, 32'd0);
    check("ready_after_clear", {31'd0, s_ready}, 32'd1);
    model_reset(2);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_clear(0);
  endtask

  task automatic freeze_idle();
    @(negedge clk);
    freeze_req = 1'b1;
    @(negedge clk);
    freeze_req = 1'b0;
    if (mst == 2) mst = 3;
    check("freeze_state", {30'd0, state}, mst);
    check("freeze_flags", {30'd0, converged, timeout}, {30'd0, conv, tout});
  endtask

  task automatic do_sample(input logic [15:0] x, input logic [15:0] d,
                           input int hold, input bit fr, input bit st);
    int n;
    bit pred;
    logic [15:0] yexp;
    yexp = ~x;
    @(negedge clk);
    s_x = x; s_d = d; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", {31'd0, s_ready}, 32'd1);
    if (!s_ready) begin
      s_valid = 1'b0;
      return;
    end
    pred = (mst == 2);
    @(negedge clk);
    s_valid = 1'b0;
    check("core_shift", {31'd0, core_shift}, 32'd1);
    check("core_adapt", {31'd0, core_adapt}, {31'd0, pred});
    check("core_x", {16'd0, core_x}, {16'd0, x});
    check("core_d", {16'd0, core_d}, {16'd0, d});
    check("busy_ready", {31'd0, s_ready}, 32'd0);
    if (fr) begin
      freeze_req = 1'b1;
      if (mst == 2) fpend = 1;
    end
    if (st) start = 1'b1;
    n = 0;
    while (!m_valid && n < 16) begin
      @(negedge clk);
      freeze_req = 1'b0;
      start = 1'b0;
      n++;
    end
    freeze_req = 1'b0;
    start = 1'b0;
    check("out_latency", n, CORE_LAT + 1);
    model_capture(int'($signed(d)));
    check("m_y", {16'd0, m_y}, {16'd0, yexp});
    check("m_e", {16'd0, m_e}, {16'd0, d});
    check("state", {30'd0, state}, mst);
    check("flags", {30'd0, converged, timeout}, {30'd0, conv, tout});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", {31'd0, s_ready}, 32'd0);
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_m_y", {16'd0, m_y}, {16'd0, yexp});
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("m_valid_drop", {31'd0, m_valid}, 32'd0);
    check("ready_after_hs", {31'd0, s_ready}, st ? 32'd0 : 32'd1);
  endtask

  task automatic reset_mid_flight(input bit at_output);
    int n;
    @(negedge clk);
    s_x = 16'h1234; s_d = 16'h0042; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (at_output) begin
      n = 0;
      while (!m_valid && n < 16) begin
        @(negedge clk);
        n++;
      end
      check("rst_pre_valid", {31'd0, m_valid}, 32'd1);
    end else begin
      check("rst_pre_shift", {31'd0, core_shift}, 32'd1);
    end
    #2 rst = 1'b0;
    #1;
    check("rst_shift", {31'd0, core_shift}, 32'd0);
    check("rst_clear", {31'd0, core_clear}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_adapt", {31'd0, core_adapt}, 32'd0);
    check("rst_flags", {30'd0, converged, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst = 1'b1; start = 1'b0; freeze_req = 1'b0; thresh = '0;
    s_valid = 1'b0; s_x = '0; s_d = '0; m_ready = 1'b0;
    core_y = '0; core_e = '0;
    model_reset(0);
    #2 rst = 1'b0;
    #1;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_outs", {26'd0, s_ready, core_shift, core_adapt, core_clear, m_valid, converged},
          32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_m_y", {16'd0, m_y}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores samples and freeze
    s_valid = 1'b1;
    freeze_req = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;
    freeze_req = 1'b0;
    @(negedge clk);
    check("idle_freeze", {30'd0, state}, 32'd0);

    // Convergence with zero error
    do_start();
    thresh = 22'd1;
    for (int i = 0; i < 256; i++) do_sample(16'($urandom), 16'd0, 0, 0, 0);
    check("conv_at_256", {31'd0, converged}, 32'd1);
    do_sample(16'($urandom), 16'd123, 10, 0, 0);
    freeze_idle();
    do_sample(16'($urandom), 16'($urandom), 0, 0, 1);
    wait_clear(-1);

    // Random errors with occasional spikes
    thresh = 22'(WIN * 300);
    for (int i = 0; i < 600 && mst == 2; i++) begin
      if ($urandom_range(0, 199) == 0) v = ($urandom_range(0, 1) != 0) ? 30000 : -30000;
      else v = int'($urandom_range(0, 600)) - 300;
      do_sample(16'($urandom), 16'(v), int'($urandom_range(0, 2)), 0, 0);
    end
    if (mst == 2) freeze_idle();

    // Freeze with a sample in flight
    do_start();
    thresh = 22'd0;
    do_sample(16'($urandom), 16'd50, 0, 1, 0);
    check("freeze_run", {30'd0, state}, 32'd3);
    do_sample(16'($urandom), 16'd60, 0, 0, 0);

    // Timeout with constant error
    do_start();
    thresh = 22'd1000;
    for (int i = 0; i < MAX_TRAIN; i++) do_sample(16'($urandom), 16'd1000, 0, 0, 0);
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    check("timeout_conv", {31'd0, converged}, 32'd0);
    do_sample(16'($urandom), 16'h8000, 0, 0, 0);

    // Saturated |e| of the most-negative code
    do_start();
    thresh = 22'(WIN * 32767 + 1);
    for (int i = 0; i < 256; i++) do_sample(16'($urandom), 16'h8000, 0, 0, 0);
    check("sat_conv", {31'd0, converged}, 32'd1);
    do_start();
    thresh = 22'(WIN * 32767);
    for (int i = 0; i < WIN; i++) do_sample(16'($urandom), 16'h8000, 0, 0, 0);
    for (int i = 0; i < 400 && mst == 2; i++) do_sample(16'($urandom), 16'd0, 0, 0, 0);
    check("sat_edge_train_len", mags.size(), 320);

    // Asynchronous reset mid-flight and with output pending
    do_start();
    reset_mid_flight(0);
    do_start();
    reset_mid_flight(1);
    do_start();
    thresh = 22'd5;
    do_sample(16'h0F0F, 16'hFFFE, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
